// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV32 5-stage pipeline control blocks:
// forwarding select codes, stage-record widths and base opcodes.
package rv_pipe_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EX_MEM  = 2'b01;
    localparam logic [1:0] FWD_MEM_WB  = 2'b10;

    localparam int REG_IDX_W = 5;
    localparam int EX_REC_W  = 1 + 3 * REG_IDX_W + 3;
    localparam int MEM_REC_W = 1 + REG_IDX_W + 1;
    localparam int WB_REC_W  = MEM_REC_W;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // The youngest producer (EX/MEM) wins over the older one (MEM/WB).
    function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
        logic [1:0] sel;
        if (mem_hit) begin
            sel = FWD_EX_MEM;
        end else if (wb_hit) begin
            sel = FWD_MEM_WB;
        end else begin
            sel = FWD_REGFILE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

    // Event counter register, never wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= CNT_ZERO;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall/flush controller for the 5-stage RV32 pipeline.
// Tracks EX/MEM/WB in a shadow scoreboard and drives enables, flushes and bypass selects.
module pipe_hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int REG_AW        = 5,
    parameter int CNT_W         = 16,
    parameter int HAS_WB_BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_is_mc,
    input  logic              ex_mc_done,
    input  logic              ex_redirect,
    output logic              pc_en,
    output logic              pc_sel_redirect,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              id_bypass_a,
    output logic              id_bypass_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [REG_AW-1:0] IDX_ZERO = {REG_AW{1'b0}};
    localparam logic              BYP_EN   = (HAS_WB_BYPASS != 0);

    logic              ex_v_r, ex_rw_r, ex_mr_r, ex_mc_r;
    logic [REG_AW-1:0] ex_rs1_r, ex_rs2_r, ex_rd_r;
    logic              mem_v_r, mem_rw_r;
    logic [REG_AW-1:0] mem_rd_r;
    logic              wb_v_r, wb_rw_r;
    logic [REG_AW-1:0] wb_rd_r;

    logic rs1_live_s, rs2_live_s, mc_busy_s, redirect_s, load_use_s;
    logic mem_hit_a_s, mem_hit_b_s, wb_hit_a_s, wb_hit_b_s;

    assign rs1_live_s = id_valid & id_use_rs1 & (id_rs1 != IDX_ZERO);
    assign rs2_live_s = id_valid & id_use_rs2 & (id_rs2 != IDX_ZERO);
    assign mc_busy_s  = ex_v_r & ex_mc_r & ~ex_mc_done;
    assign redirect_s = ex_v_r & ex_redirect & ~mc_busy_s;
    assign load_use_s = ex_v_r & ex_mr_r & (ex_rd_r != IDX_ZERO)
                      & ((rs1_live_s & (id_rs1 == ex_rd_r)) | (rs2_live_s & (id_rs2 == ex_rd_r)))
                      & ~redirect_s & ~mc_busy_s;

    // Pipeline enables and flushes, highest-priority hazard first
    always_comb begin
        pc_en           = 1'b1;
        pc_sel_redirect = 1'b0;
        if_id_en        = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_en        = 1'b1;
        id_ex_flush     = 1'b0;
        ex_mem_flush    = 1'b0;
        if (mc_busy_s) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (redirect_s) begin
            pc_sel_redirect = 1'b1;
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
        end else if (load_use_s) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else begin
            pc_en = 1'b1;
        end
    end

    assign mem_hit_a_s = mem_v_r & mem_rw_r & (mem_rd_r == ex_rs1_r) & (ex_rs1_r != IDX_ZERO);
    assign mem_hit_b_s = mem_v_r & mem_rw_r & (mem_rd_r == ex_rs2_r) & (ex_rs2_r != IDX_ZERO);
    assign wb_hit_a_s  = wb_v_r & wb_rw_r & (wb_rd_r == ex_rs1_r) & (ex_rs1_r != IDX_ZERO);
    assign wb_hit_b_s  = wb_v_r & wb_rw_r & (wb_rd_r == ex_rs2_r) & (ex_rs2_r != IDX_ZERO);
    assign fwd_a_sel   = fwd_pick(mem_hit_a_s, wb_hit_a_s);
    assign fwd_b_sel   = fwd_pick(mem_hit_b_s, wb_hit_b_s);

    assign id_bypass_a = BYP_EN & wb_v_r & wb_rw_r & (wb_rd_r == id_rs1) & (id_rs1 != IDX_ZERO);
    assign id_bypass_b = BYP_EN & wb_v_r & wb_rw_r & (wb_rd_r == id_rs2) & (id_rs2 != IDX_ZERO);

    // Shadow scoreboard; a bubble in EX clears the whole record so it cannot match anything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_v_r   <= 1'b0;
            ex_rs1_r <= IDX_ZERO;
            ex_rs2_r <= IDX_ZERO;
            ex_rd_r  <= IDX_ZERO;
            ex_rw_r  <= 1'b0;
            ex_mr_r  <= 1'b0;
            ex_mc_r  <= 1'b0;
            mem_v_r  <= 1'b0;
            mem_rd_r <= IDX_ZERO;
            mem_rw_r <= 1'b0;
            wb_v_r   <= 1'b0;
            wb_rd_r  <= IDX_ZERO;
            wb_rw_r  <= 1'b0;
        end else if (mc_busy_s) begin
            mem_v_r <= 1'b0;
            wb_v_r  <= mem_v_r;
            wb_rd_r <= mem_rd_r;
            wb_rw_r <= mem_rw_r;
        end else begin
            mem_v_r  <= ex_v_r;
            mem_rd_r <= ex_rd_r;
            mem_rw_r <= ex_rw_r;
            wb_v_r   <= mem_v_r;
            wb_rd_r  <= mem_rd_r;
            wb_rw_r  <= mem_rw_r;
            if (redirect_s || load_use_s) begin
                ex_v_r   <= 1'b0;
                ex_rs1_r <= IDX_ZERO;
                ex_rs2_r <= IDX_ZERO;
                ex_rd_r  <= IDX_ZERO;
                ex_rw_r  <= 1'b0;
                ex_mr_r  <= 1'b0;
                ex_mc_r  <= 1'b0;
            end else begin
                ex_v_r   <= id_valid;
                ex_rs1_r <= id_rs1;
                ex_rs2_r <= id_rs2;
                ex_rd_r  <= id_rd;
                ex_rw_r  <= id_reg_write;
                ex_mr_r  <= id_mem_read;
                ex_mc_r  <= id_is_mc;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mc_busy_s | load_use_s),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect_s),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus randomized bench for pipe_hazard_ctrl against a stage-record reference model;
// a second instance with 3-bit counters shares the stimulus to exercise saturation.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, id_is_mc;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_mc_done, ex_redirect;

    logic        pc_en, pc_sel_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        id_bypass_a, id_bypass_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_en, s_pc_sel, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_flush, s_ex_mem_flush;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic        s_byp_a, s_byp_b;
    logic [2:0]  s_stall_cnt, s_flush_cnt;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       mc;
    } rec_t;

    rec_t ex_m, mem_m, wb_m;
    int   stall_n, flush_n;
    int   checks = 0;
    int   errors = 0;
    logic e_busy, e_redir, e_lu;

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_is_mc(id_is_mc),
        .ex_mc_done(ex_mc_done), .ex_redirect(ex_redirect),
        .pc_en(pc_en), .pc_sel_redirect(pc_sel_redirect), .if_id_en(if_id_en),
        .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .id_bypass_a(id_bypass_a), .id_bypass_b(id_bypass_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(3)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_is_mc(id_is_mc),
        .ex_mc_done(ex_mc_done), .ex_redirect(ex_redirect),
        .pc_en(s_pc_en), .pc_sel_redirect(s_pc_sel), .if_id_en(s_if_id_en),
        .if_id_flush(s_if_id_flush), .id_ex_en(s_id_ex_en), .id_ex_flush(s_id_ex_flush),
        .ex_mem_flush(s_ex_mem_flush), .fwd_a_sel(s_fwd_a), .fwd_b_sel(s_fwd_b),
        .id_bypass_a(s_byp_a), .id_bypass_b(s_byp_b),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    // Which stage holds the youngest writer of src (x0 is never forwarded).
    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (src == 5'd0) return 2'd0;
        if (mem_m.v && mem_m.rw && mem_m.rd == src) return 2'd1;
        if (wb_m.v && wb_m.rw && wb_m.rd == src) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic id_reads(input logic [4:0] r);
        return id_valid && (r != 5'd0) &&
               ((id_use_rs1 && id_rs1 == r) || (id_use_rs2 && id_rs2 == r));
    endfunction

    function automatic logic exp_byp(input logic [4:0] src);
        return wb_m.v && wb_m.rw && (wb_m.rd == src) && (src != 5'd0);
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mc,
                         input logic done, input logic redir);
        logic e_stall;
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_is_mc = mc;
        ex_mc_done = done; ex_redirect = redir;
        #1;
        e_busy  = ex_m.v && ex_m.mc && !done;
        e_redir = ex_m.v && redir && !e_busy;
        e_lu    = !e_busy && !e_redir && ex_m.v && ex_m.mr && id_reads(ex_m.rd);
        e_stall = e_busy || e_lu;
        chk("pc_en", pc_en, !e_stall);
        chk("pc_sel_redirect", pc_sel_redirect, e_redir);
        chk("if_id_en", if_id_en, !e_stall);
        chk("if_id_flush", if_id_flush, e_redir);
        chk("id_ex_en", id_ex_en, !e_busy);
        chk("id_ex_flush", id_ex_flush, e_redir || e_lu);
        chk("ex_mem_flush", ex_mem_flush, e_busy);
        chk("fwd_a_sel", fwd_a_sel, exp_fwd(ex_m.rs1));
        chk("fwd_b_sel", fwd_b_sel, exp_fwd(ex_m.rs2));
        chk("id_bypass_a", id_bypass_a, exp_byp(id_rs1));
        chk("id_bypass_b", id_bypass_b, exp_byp(id_rs2));
        chk("stall_cnt", stall_cnt, sat(stall_n, 65535));
        chk("flush_cnt", flush_cnt, sat(flush_n, 65535));
        chk("sat_stall_cnt", s_stall_cnt, sat(stall_n, 7));
        chk("sat_flush_cnt", s_flush_cnt, sat(flush_n, 7));
        chk("sat_pc_en", s_pc_en, !e_stall);
        chk("sat_pc_sel", s_pc_sel, e_redir);
        chk("sat_if_id_en", s_if_id_en, !e_stall);
        chk("sat_if_id_flush", s_if_id_flush, e_redir);
        chk("sat_id_ex_en", s_id_ex_en, !e_busy);
        chk("sat_id_ex_flush", s_id_ex_flush, e_redir || e_lu);
        chk("sat_ex_mem_flush", s_ex_mem_flush, e_busy);
        chk("sat_fwd", {s_fwd_a, s_fwd_b}, {exp_fwd(ex_m.rs1), exp_fwd(ex_m.rs2)});
        chk("sat_bypass", {s_byp_a, s_byp_b}, {exp_byp(id_rs1), exp_byp(id_rs2)});
    endtask

    task automatic tick();
        @(posedge clk);
        if (e_busy || e_lu) stall_n++;
        if (e_redir) flush_n++;
        wb_m = mem_m;
        if (e_busy) begin
            mem_m.v = 1'b0;
        end else begin
            mem_m = ex_m;
            if (e_redir || e_lu) ex_m = '0;
            else ex_m = {id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, id_is_mc};
        end
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        ex_m = '0; mem_m = '0; wb_m = '0;
        stall_n = 0; flush_n = 0;
        e_busy = 1'b0; e_redir = 1'b0; e_lu = 1'b0;
        chk("rst_pc_en", pc_en, 1'b1);
        chk("rst_if_id_en", if_id_en, 1'b1);
        chk("rst_id_ex_en", id_ex_en, 1'b1);
        chk("rst_flushes", {pc_sel_redirect, if_id_flush, id_ex_flush, ex_mem_flush}, 4'h0);
        chk("rst_selects", {fwd_a_sel, fwd_b_sel, id_bypass_a, id_bypass_b}, 6'h00);
        chk("rst_counters", {stall_cnt, flush_cnt}, 32'h0);
        chk("rst_sat_counters", {s_stall_cnt, s_flush_cnt}, 6'h00);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        logic       rv, ru1, ru2, rrw, rmr, rmc, rdone, rredir;
        logic [4:0] rrs1, rrs2, rrd;
        id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rd = 5'd0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_is_mc = 1'b0;
        ex_mc_done = 1'b0; ex_redirect = 1'b0;
        do_reset();

        // ALU chain on x5: EX/MEM forward, then MEM/WB forward
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("alu_fwd_a_exmem", fwd_a_sel, 2'b01);
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("alu_fwd_b_memwb", fwd_b_sel, 2'b10);
        chk("alu_no_stall", stall_cnt, 16'd0);
        tick();

        // Load-use on x6 through rs2
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd1, 5'd6, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_stall", {pc_en, if_id_en, id_ex_flush}, 3'b001);
        tick();
        drive(1'b1, 5'd1, 5'd6, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_release", pc_en, 1'b1);
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_fwd_b", fwd_b_sel, 2'b10);
        chk("lu_stall_cnt", stall_cnt, 16'd1);
        tick();

        // No stall: unused sources, or a load to x0
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd6, 5'd6, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("nouse_no_stall", pc_en, 1'b1);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd0, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("x0_load_no_stall", pc_en, 1'b1);
        tick();

        // Redirect beats a pending load-use
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("br_outputs", {pc_sel_redirect, if_id_flush, id_ex_flush, pc_en}, 4'hF);
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("br_flush_cnt", flush_cnt, 16'd1);
        chk("br_stall_cnt", stall_cnt, 16'd1);
        tick();

        // Four-cycle DIV with an ignored redirect pulse
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, (i == 1) ? 1'b1 : 1'b0);
            chk("mc_busy", {pc_en, ex_mem_flush, pc_sel_redirect}, 3'b010);
            tick();
        end
        drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("mc_done_advance", pc_en, 1'b1);
        chk("mc_stall_cnt", stall_cnt, 16'd5);
        chk("mc_flush_cnt", flush_cnt, 16'd1);
        tick();

        // Ten load-use stalls in a row saturate the 3-bit counter
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        end
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_hold_7", s_stall_cnt, 3'd7);
        chk("wide_stall_15", stall_cnt, 16'd15);
        tick();

        // Reset while a load-use stall is being signalled
        drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_stall", pc_en, 1'b0);
        do_reset();

        // Randomized traffic on a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            rv     = ($urandom_range(0, 9) != 0);
            rrs1   = 5'($urandom_range(0, 7));
            rrs2   = 5'($urandom_range(0, 7));
            rrd    = 5'($urandom_range(0, 7));
            ru1    = ($urandom_range(0, 3) != 0);
            ru2    = ($urandom_range(0, 1) != 0);
            rrw    = ($urandom_range(0, 3) != 0);
            rmr    = ($urandom_range(0, 3) == 0);
            rmc    = ($urandom_range(0, 9) == 0);
            rdone  = ($urandom_range(0, 4) < 2);
            rredir = ($urandom_range(0, 6) == 0);
            drive(rv, rrs1, rrs2, ru1, ru2, rrd, rrw, rmr, rmc, rdone, rredir);
            tick();
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Centralised hazard, forwarding and stall/flush controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
- Keeps its own shadow scoreboard of the EX, MEM and WB stages.
- Generates pipeline-register enables and flushes, EX operand forwarding selects, ID write-through bypass, and saturating stall/flush counters.
- Adds load-use stall, branch flush and multi-cycle EX (MUL/DIV) stall handling to the existing datapath.

Parameters:
- REG_AW, 5, register index width (2**REG_AW architectural registers; index 0 is hardwired zero).
- CNT_W, 16, width of the stall and flush performance counters.
- HAS_WB_BYPASS, 1, enables the ID-stage regfile write-through bypass outputs (0 ties them low).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- id_valid  in  1  the IF/ID register holds a real instruction
- id_rs1, id_rs2  in  REG_AW  source indices of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  the instruction in ID actually reads that source
- id_rd  in  REG_AW  destination index of the instruction in ID
- id_reg_write, id_mem_read, id_is_mc  in  1  decoded controls of the instruction in ID
- ex_mc_done  in  1  multi-cycle ALU result valid this cycle
- ex_redirect  in  1  branch/jump resolved taken in EX
- pc_en  out  1  PC register load enable
- pc_sel_redirect  out  1  PC loads the EX redirect target
- if_id_en, if_id_flush  out  1  IF/ID hold enable / clear to bubble
- id_ex_en, id_ex_flush  out  1  ID/EX hold enable / insert bubble
- ex_mem_flush  out  1  insert bubble into EX/MEM
- fwd_a_sel, fwd_b_sel  out  2  EX operand source: 00 ID/EX, 01 EX/MEM result, 10 MEM/WB writeback value
- id_bypass_a, id_bypass_b  out  1  ID read data replaced by the WB value
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Shadow state: ex_{v,rs1,rs2,rd,rw,mr,mc}, mem_{v,rd,rw}, wb_{v,rd,rw}. Reset is asynchronous; it clears all valid bits and both counters.
- Outputs directly after reset: pc_en=1, if_id_en=1, id_ex_en=1, all flush and select outputs 0, counters 0.
- A source is "live" when id_valid=1, its use bit is set and its index is non-zero. Register x0 never creates a hazard or a forward.
- mc_busy = ex_v & ex_mc & ~ex_mc_done.
  - pc_en, if_id_en and id_ex_en are 0; ex_mem_flush is 1.
  - EX shadow holds; MEM shadow takes a bubble (v=0); WB advances.
  - ex_redirect is ignored while mc_busy.
- redirect = ex_v & ex_redirect & ~mc_busy.
  - pc_sel_redirect=1, pc_en=1, if_id_flush=1, id_ex_flush=1.
  - EX shadow becomes invalid next cycle.
  - flush_cnt increments by 1.
- load_use = ex_v & ex_mr & ex_rd!=0 & (a live source equals ex_rd), and neither redirect nor mc_busy is active.
  - pc_en=0, if_id_en=0, id_ex_flush=1.
  - MEM and WB advance.
  - Exactly one bubble per load; on the next cycle the load sits in MEM and the consumer re-evaluates with no hazard.
- Priority order: mc_busy > redirect > load_use > normal advance.
- stall_cnt increments on every mc_busy or load_use cycle. Both counters saturate at 2**CNT_W-1 and do not wrap.
- Normal advance: EX shadow loads the ID fields (v=id_valid), MEM loads from EX, WB loads from MEM.
- Forwarding (combinational from shadow state, EX operand a shown; operand b identical using ex_rs2):
  - 01 if mem_v & mem_rw & mem_rd==ex_rs1 & ex_rs1!=0;
  - else 10 if wb_v & wb_rw & wb_rd==ex_rs1 & ex_rs1!=0;
  - else 00.
  - MEM has priority over WB (youngest producer wins).
- ID bypass: id_bypass_a = HAS_WB_BYPASS & wb_v & wb_rw & wb_rd==id_rs1 & id_rs1!=0. Same rule for b with id_rs2.
- Reset asserted mid-stall or mid-flush: all shadow state clears immediately; outputs return to the post-reset values on the next evaluation.
- All outputs are combinational from the shadow state and current inputs. The only registers are the shadow state and the counters.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - FWD_REGFILE=2'b00, FWD_EX_MEM=2'b01, FWD_MEM_WB=2'b10;
  - the stage-record field widths;
  - opcode constants OP_LOAD, OP_BRANCH, OP_JAL, OP_JALR.
- One sub-module is natural: sat_counter (parametrised width, inc input, saturating), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Back-to-back ALU dependency: add x5 (EX→MEM), then id rs1=5 moving into EX → fwd_a_sel=01 for one cycle, then 10 if the next instruction also reads x5; stall_cnt stays 0.
- Load-use: lw x6 in EX, ID has rs2=6 with use_rs2=1 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle fwd_b_sel=10; stall_cnt=1.
- Load followed by an instruction with rd=6 but use bits 0, or a load to x0 → no stall, pc_en=1.
- Branch taken with a load-use pending in ID in the same cycle → pc_sel_redirect=1, if_id_flush=1, id_ex_flush=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- DIV in EX with ex_mc_done low for 4 cycles, then high, and ex_redirect pulsed during the busy period → 4 cycles with pc_en=0 and ex_mem_flush=1, redirect ignored, stall_cnt=4; normal advance resumes on the done cycle.
- CNT_W=3, 10 consecutive load-use stalls → stall_cnt holds at 7. Reset asserted mid-stall → all outputs return to their reset values immediately and counters read 0.
